// File: rtl/vmem_pkg.sv
// Shared types and default sizes for the frame-buffer arbiter.
// Grant and fill-state encodings are shared by the top and its round-robin helper.
package vmem_pkg;

    localparam int VMEM_AW = 19;
    localparam int VMEM_DW = 24;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_FILL,
        GNT_WR0,
        GNT_WR1
    } grant_e;

    typedef enum logic {
        FS_IDLE,
        FS_FILL
    } fill_state_e;

endpackage

// File: rtl/vmem_rr_arb2.sv
// Two-input round-robin arbiter for the pixel writers.
// The tie-break pointer moves only when a grant is actually issued.
module vmem_rr_arb2
    import vmem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q;
    logic prio_d;

    // prio_q = 1 means writer 1 wins a tie, i.e. writer 0 was served last.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = prio_q ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end

        prio_d = prio_q;
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: display reads beat the clear-screen fill,
// which beats the two round-robin pixel writers. All RAM controls are registered.
module vmem_arbiter
    import vmem_pkg::*;
#(
    parameter int AW        = VMEM_AW,
    parameter int DW        = VMEM_DW,
    parameter int FILL_LAST = (1 << AW) - 1
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,

    input  logic          wr0_valid,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_ready,

    input  logic          wr1_valid,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_ready,

    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] FILL_LAST_ADDR = AW'(FILL_LAST);

    grant_e        grant;
    logic [1:0]    wr_gnt;
    logic          arb_en;

    logic          ready_ok_q, ready_ok_d;
    fill_state_e   fill_state_q, fill_state_d;
    logic [AW-1:0] fill_ptr_q, fill_ptr_d;
    logic [DW-1:0] fill_color_q, fill_color_d;
    logic          fill_done_q, fill_done_d;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          rd_pend_q, rd_pend_d;
    logic          disp_valid_q, disp_valid_d;

    // Writers only compete for slots the display and the fill leave free.
    assign arb_en = ready_ok_q && !disp_req && (fill_state_q == FS_IDLE);

    vmem_rr_arb2 u_rr_arb (
        .clk    (clk),
        .resetn (resetn),
        .en     (arb_en),
        .valid  ({wr1_valid, wr0_valid}),
        .grant  (wr_gnt)
    );

    always_comb begin
        grant = GNT_NONE;
        if (ready_ok_q) begin
            if (disp_req) begin
                grant = GNT_DISP;
            end else if (fill_state_q == FS_FILL) begin
                grant = GNT_FILL;
            end else if (wr_gnt[0]) begin
                grant = GNT_WR0;
            end else if (wr_gnt[1]) begin
                grant = GNT_WR1;
            end
        end
    end

    always_comb begin
        ready_ok_d   = 1'b1;
        fill_state_d = fill_state_q;
        fill_ptr_d   = fill_ptr_q;
        fill_color_d = fill_color_q;
        fill_done_d  = 1'b0;

        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        // Read data returns one cycle after the RAM sees the access.
        rd_pend_d    = (grant == GNT_DISP);
        disp_valid_d = rd_pend_q;

        case (grant)
            GNT_DISP: begin
                mem_en_d   = 1'b1;
                mem_addr_d = disp_addr;
            end
            GNT_FILL: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = fill_ptr_q;
                mem_wdata_d = fill_color_q;
            end
            GNT_WR0: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr0_addr;
                mem_wdata_d = wr0_data;
            end
            GNT_WR1: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr1_addr;
                mem_wdata_d = wr1_data;
            end
            default: ;
        endcase

        case (fill_state_q)
            FS_IDLE: begin
                if (ready_ok_q && fill_start) begin
                    fill_state_d = FS_FILL;
                    fill_ptr_d   = '0;
                    fill_color_d = fill_color;
                end
            end
            FS_FILL: begin
                // A display preemption simply leaves the pointer where it is.
                if (grant == GNT_FILL) begin
                    if (fill_ptr_q == FILL_LAST_ADDR) begin
                        fill_state_d = FS_IDLE;
                        fill_done_d  = 1'b1;
                    end else begin
                        fill_ptr_d = fill_ptr_q + AW'(1);
                    end
                end
            end
            default: fill_state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_ok_q   <= 1'b0;
            fill_state_q <= FS_IDLE;
            fill_ptr_q   <= '0;
            fill_color_q <= '0;
            fill_done_q  <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_pend_q    <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            ready_ok_q   <= ready_ok_d;
            fill_state_q <= fill_state_d;
            fill_ptr_q   <= fill_ptr_d;
            fill_color_q <= fill_color_d;
            fill_done_q  <= fill_done_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_pend_q    <= rd_pend_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign wr0_ready  = (grant == GNT_WR0);
    assign wr1_ready  = (grant == GNT_WR1);
    assign fill_busy  = (fill_state_q == FS_FILL);
    assign fill_done  = fill_done_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q ? mem_rdata : '0;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter with a 16-entry frame buffer.
// A behavioural RAM sits on the mem port; a cycle-level reference model predicts every output.
module tb_vmem_arbiter;

    localparam int AW = 4;
    localparam int DW = 24;
    localparam logic [3:0] LAST = 4'd15;

    logic          clk = 1'b0;
    logic          resetn;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          wr0_valid, wr1_valid;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ready, wr1_ready;
    logic          fill_start;
    logic [DW-1:0] fill_color;
    logic          fill_busy, fill_done;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    vmem_arbiter #(.AW(AW), .DW(DW), .FILL_LAST(15)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr0_valid  (wr0_valid),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_ready  (wr0_ready),
        .wr1_valid  (wr1_valid),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_ready  (wr1_ready),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM attached to the arbiter
    logic [DW-1:0] ram [16] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: who owns the RAM this cycle, and what each pipeline stage should show
    bit            rok_m, rr_m, filling_m, done_m, m_en, m_we, dv_m;
    logic [3:0]    fptr_m, m_addr;
    logic [DW-1:0] fcol_m, m_wdata, rd_m;
    logic [DW-1:0] ram_m [16] = '{default: '0};

    // 0 none, 1 display, 2 fill, 3 writer 0, 4 writer 1
    function automatic int exp_grant();
        if (!rok_m)                  return 0;
        if (disp_req)                return 1;
        if (filling_m)               return 2;
        if (wr0_valid && wr1_valid)  return rr_m ? 4 : 3;
        if (wr0_valid)               return 3;
        if (wr1_valid)               return 4;
        return 0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        int g;
        if (!resetn) begin
            rok_m = 0; rr_m = 0; filling_m = 0; done_m = 0;
            m_en = 0; m_we = 0; dv_m = 0;
            fptr_m = '0; m_addr = '0; fcol_m = '0; m_wdata = '0;
        end else begin
            g = exp_grant();
            if (m_en && m_we) ram_m[m_addr] = m_wdata;
            dv_m = m_en && !m_we;
            if (dv_m) rd_m = ram_m[m_addr];
            done_m = 0;
            case (g)
                1: begin m_en = 1; m_we = 0; m_addr = disp_addr; end
                2: begin m_en = 1; m_we = 1; m_addr = fptr_m; m_wdata = fcol_m; end
                3: begin m_en = 1; m_we = 1; m_addr = wr0_addr; m_wdata = wr0_data; end
                4: begin m_en = 1; m_we = 1; m_addr = wr1_addr; m_wdata = wr1_data; end
                default: begin m_en = 0; m_we = 0; end
            endcase
            if (filling_m) begin
                if (g == 2) begin
                    if (fptr_m == LAST) begin filling_m = 0; done_m = 1; end
                    else fptr_m = fptr_m + 4'd1;
                end
            end else if (fill_start && rok_m) begin
                filling_m = 1; fptr_m = '0; fcol_m = fill_color;
            end
            if (g == 3) rr_m = 1;
            if (g == 4) rr_m = 0;
            rok_m = 1;
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        disp_req = 0; disp_addr = '0;
        wr0_valid = 0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 0; wr1_addr = '0; wr1_data = '0;
        fill_start = 0; fill_color = '0;
    endtask

    task automatic do_reset();
        resetn = 0;
        clear_inputs();
        next_cycle();
        resetn = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [58:0] obs;
        resetn = 0;
        clear_inputs();
        wr0_valid = 1; wr1_valid = 1; disp_req = 1; fill_start = 1;
        @(negedge clk);
        #1;
        obs = {wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata,
               disp_valid, disp_data, fill_busy, fill_done};
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
        end
        resetn = 1;
        disp_req = 0; fill_start = 0; wr1_valid = 0;
        #1;
        n_cmp++;
        if (wr0_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ready_gated_after_release: got %b expected 0", wr0_ready);
        end
        wr0_valid = 0;
        next_cycle();
    endtask

    task automatic test_single_write();
        wr0_valid = 1; wr0_addr = 4'h5; wr0_data = 24'hFF0000;
        #1;
        n_cmp++;
        if ({wr0_ready, wr1_ready} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL single_wr_ready: got %b expected 10", {wr0_ready, wr1_ready});
        end
        next_cycle();
        wr0_valid = 0; wr0_data = 24'h123456;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 4'h5, 24'hFF0000}) begin
            n_bad++;
            $display("[TB] FAIL single_wr_mem: got %h expected %h",
                     {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 4'h5, 24'hFF0000});
        end
        next_cycle();
        disp_req = 1; disp_addr = 4'h5;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr} !== {2'b00, 4'h5}) begin
            n_bad++;
            $display("[TB] FAIL idle_mem_hold: got %h expected %h", {mem_en, mem_we, mem_addr}, {2'b00, 4'h5});
        end
        next_cycle();
        disp_req = 0;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, disp_valid} !== {2'b10, 4'h5, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL read_mem: got %h expected %h", {mem_en, mem_we, mem_addr, disp_valid}, {2'b10, 4'h5, 1'b0});
        end
        next_cycle();
        n_cmp++;
        if ({disp_valid, disp_data} !== {1'b1, 24'hFF0000}) begin
            n_bad++;
            $display("[TB] FAIL read_data: got %h expected %h", {disp_valid, disp_data}, {1'b1, 24'hFF0000});
        end
        next_cycle();
        n_cmp++;
        if ({disp_valid, disp_data} !== 25'h0) begin
            n_bad++;
            $display("[TB] FAIL read_data_idle: got %h expected 0", {disp_valid, disp_data});
        end
    endtask

    task automatic test_round_robin();
        int xfers = 0;
        logic [3:0] prev_addr = '0;
        do_reset();
        wr0_addr = 4'h1; wr0_data = 24'h0000AA;
        wr1_addr = 4'h9; wr1_data = 24'h0000BB;
        for (int i = 0; i < 4; i++) begin
            wr0_valid = 1; wr1_valid = 1;
            #1;
            n_cmp++;
            if ({wr0_ready, wr1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", i, {wr0_ready, wr1_ready},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                n_cmp++;
                if ({mem_we, mem_addr} !== {1'b1, prev_addr}) begin
                    n_bad++;
                    $display("[TB] FAIL rr_mem[%0d]: got %h expected %h", i, {mem_we, mem_addr}, {1'b1, prev_addr});
                end
            end
            if (wr0_ready || wr1_ready) xfers++;
            prev_addr = (i % 2 == 0) ? 4'h1 : 4'h9;
            next_cycle();
        end
        wr0_valid = 0; wr1_valid = 0;
        #1;
        n_cmp++;
        if (xfers != 4 || mem_addr !== 4'h9 || mem_wdata !== 24'h0000BB) begin
            n_bad++;
            $display("[TB] FAIL rr_count: got %0d/%h expected 4/9", xfers, mem_addr);
        end
    endtask

    task automatic test_disp_priority();
        for (int i = 0; i < 11; i++) begin
            disp_req = (i < 8);
            disp_addr = 4'(i);
            wr0_valid = (i < 9); wr1_valid = (i < 9);
            #1;
            if (i < 8) begin
                n_cmp++;
                if ({wr0_ready, wr1_ready} !== 2'b00) begin
                    n_bad++;
                    $display("[TB] FAIL disp_blocks_wr[%0d]: got %b expected 00", i, {wr0_ready, wr1_ready});
                end
            end
            if (i == 8) begin
                n_cmp++;
                if ({wr0_ready, wr1_ready} !== 2'b10) begin
                    n_bad++;
                    $display("[TB] FAIL wr_resume: got %b expected 10", {wr0_ready, wr1_ready});
                end
            end
            n_cmp++;
            if (disp_valid !== (i >= 2 && i < 10) || disp_data !== (dv_m ? rd_m : 24'h0)) begin
                n_bad++;
                $display("[TB] FAIL disp_stream[%0d]: got %b/%h expected %b/%h", i, disp_valid, disp_data,
                         (i >= 2 && i < 10), dv_m ? rd_m : 24'h0);
            end
            next_cycle();
        end
    endtask

    task automatic test_fill();
        wr0_addr = 4'h2; wr1_addr = 4'hA;
        fill_start = 1; fill_color = 24'h00FF00;
        #1;
        next_cycle();
        for (int k = 0; k < 18; k++) begin
            fill_start = (k == 5);
            fill_color = (k == 5) ? 24'h123456 : 24'h00FF00;
            wr0_valid = (k < 16); wr1_valid = (k < 16);
            #1;
            n_cmp++;
            if ({fill_busy, fill_done, wr0_ready, wr1_ready} !== {k < 16, k == 16, 2'b00}) begin
                n_bad++;
                $display("[TB] FAIL fill_status[%0d]: got %b expected %b", k,
                         {fill_busy, fill_done, wr0_ready, wr1_ready}, {k < 16, k == 16, 2'b00});
            end
            if (k >= 1 && k <= 16) begin
                n_cmp++;
                if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 4'(k - 1), 24'h00FF00}) begin
                    n_bad++;
                    $display("[TB] FAIL fill_write[%0d]: got %h expected %h", k,
                             {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 4'(k - 1), 24'h00FF00});
                end
            end
            if (k == 17) begin
                n_cmp++;
                if (mem_en !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL fill_after_idle: got %b expected 0", mem_en);
                end
            end
            next_cycle();
        end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (ram[a] !== 24'h00FF00) begin
                n_bad++;
                $display("[TB] FAIL fill_ram[%0d]: got %h expected 00ff00", a, ram[a]);
            end
        end
    endtask

    task automatic test_fill_with_disp();
        bit done_seen = 0;
        int k_done = -1;
        int wr_cnt = 0;
        fill_start = 1; fill_color = 24'h333333;
        #1;
        next_cycle();
        fill_start = 0;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            disp_req = (k >= 4 && k < 7);
            disp_addr = 4'(k);
            #1;
            if (mem_en && mem_we) begin
                n_cmp++;
                if (mem_addr !== 4'(wr_cnt) || mem_wdata !== 24'h333333) begin
                    n_bad++;
                    $display("[TB] FAIL fill_disp_write[%0d]: got %h/%h expected %h/333333", k, mem_addr, mem_wdata, 4'(wr_cnt));
                end
                wr_cnt++;
            end
            if (fill_done) begin
                done_seen = 1;
                k_done = k;
            end
            next_cycle();
        end
        disp_req = 0;
        n_cmp++;
        if (!done_seen || k_done != 19 || wr_cnt != 16) begin
            n_bad++;
            $display("[TB] FAIL fill_disp_done: got cycle %0d writes %0d expected cycle 19 writes 16", k_done, wr_cnt);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit done_seen = 0;
        int k_done = -1;
        logic [58:0] obs;
        fill_start = 1; fill_color = 24'hC0FFEE;
        #1;
        next_cycle();
        fill_start = 0;
        for (int k = 0; k < 7; k++) next_cycle();
        resetn = 0;
        wr0_valid = 1; disp_req = 0;
        #1;
        obs = {wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata,
               disp_valid, disp_data, fill_busy, fill_done};
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("[TB] FAIL midfill_reset_outputs: got %h expected 0", obs);
        end
        next_cycle();
        resetn = 1;
        wr0_valid = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            n_cmp++;
            if ({fill_busy, fill_done} !== 2'b00) begin
                n_bad++;
                $display("[TB] FAIL midfill_abort[%0d]: got %b expected 00", k, {fill_busy, fill_done});
            end
            next_cycle();
        end
        fill_start = 1; fill_color = 24'h0000FF;
        #1;
        next_cycle();
        fill_start = 0;
        #1;
        n_cmp++;
        if (fill_busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL refill_busy: got %b expected 1", fill_busy);
        end
        for (int k = 0; k < 40 && !done_seen; k++) begin
            if (fill_done) begin done_seen = 1; k_done = k; end
            else next_cycle();
        end
        n_cmp++;
        if (!done_seen || k_done != 16) begin
            n_bad++;
            $display("[TB] FAIL refill_done: got cycle %0d expected 16", k_done);
        end
        next_cycle();
    endtask

    task automatic test_start_with_writer();
        bit done_seen = 0;
        int k_done = -1;
        fill_start = 1; fill_color = 24'hABCDEF;
        wr1_valid = 1; wr1_addr = 4'h3; wr1_data = 24'h0F0F0F;
        #1;
        n_cmp++;
        if ({wr0_ready, wr1_ready, fill_busy} !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL start_wr1_grant: got %b expected 010", {wr0_ready, wr1_ready, fill_busy});
        end
        next_cycle();
        fill_start = 0; wr1_valid = 0;
        #1;
        n_cmp++;
        if ({fill_busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 24'h0F0F0F}) begin
            n_bad++;
            $display("[TB] FAIL start_wr1_next: got %h expected %h",
                     {fill_busy, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h3, 24'h0F0F0F});
        end
        for (int k = 0; k < 40 && !done_seen; k++) begin
            if (fill_done) begin done_seen = 1; k_done = k; end
            else next_cycle();
        end
        n_cmp++;
        if (!done_seen || k_done != 16) begin
            n_bad++;
            $display("[TB] FAIL start_wr1_fill_done: got cycle %0d expected 16", k_done);
        end
        next_cycle();
    endtask

    task automatic test_random();
        bit x0 = 0, x1 = 0;
        int g;
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!wr0_valid || x0) begin
                wr0_valid = 1'($urandom_range(0, 1));
                wr0_addr  = 4'($urandom);
                wr0_data  = 24'($urandom);
            end
            if (!wr1_valid || x1) begin
                wr1_valid = 1'($urandom_range(0, 1));
                wr1_addr  = 4'($urandom);
                wr1_data  = 24'($urandom);
            end
            disp_req   = ($urandom_range(0, 2) == 0);
            disp_addr  = 4'($urandom);
            fill_start = ($urandom_range(0, 63) == 0);
            fill_color = 24'($urandom);
            #1;
            g = exp_grant();
            n_cmp++;
            if ({wr0_ready, wr1_ready} !== {g == 3, g == 4}) begin
                n_bad++;
                $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, {wr0_ready, wr1_ready}, {g == 3, g == 4});
            end
            n_cmp++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {m_en, m_we, m_addr, m_wdata}) begin
                n_bad++;
                $display("[TB] FAIL rand_mem[%0d]: got %h expected %h", c,
                         {mem_en, mem_we, mem_addr, mem_wdata}, {m_en, m_we, m_addr, m_wdata});
            end
            n_cmp++;
            if ({disp_valid, disp_data} !== {dv_m, dv_m ? rd_m : 24'h0}) begin
                n_bad++;
                $display("[TB] FAIL rand_disp[%0d]: got %h expected %h", c,
                         {disp_valid, disp_data}, {dv_m, dv_m ? rd_m : 24'h0});
            end
            n_cmp++;
            if ({fill_busy, fill_done} !== {filling_m, done_m}) begin
                n_bad++;
                $display("[TB] FAIL rand_fill[%0d]: got %b expected %b", c, {fill_busy, fill_done}, {filling_m, done_m});
            end
            x0 = (g == 3);
            x1 = (g == 4);
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_disp_priority();
        test_fill();
        test_fill_with_disp();
        test_reset_mid_fill();
        test_start_with_writer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
